djs130_io_ctrl: RTL
===================

DJS130_IO_CTRL -- requirements
Module: djs130_io_ctrl

Interface
REQ-001 Parameter STB_CYC, default 2, range 1..15: number of cycles a device control strobe is held.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 i_clk  in  1  system clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_io_req  in  1  CPU I/O request, sampled high for one cycle.
REQ-006 i_io_dms  in  6  target device code.
REQ-007 i_io_kz  in  9  control field; bit3 QAS, bit6 KZS (start), bit7 KZC (clear), bit1 DO (data out).
REQ-008 i_io_wdata  in  16  CPU write data.
REQ-009 o_io_ack  out  1  one-cycle completion pulse.
REQ-010 o_io_rdata  out  16  data captured from the target device.
REQ-011 o_io_zt  out  2  target status; bit1 busy, bit0 done.
REQ-012 o_io_nodev  out  1  high with o_io_ack when no slot matched.
REQ-013 o_dev_kz  out  36  per-slot control field; slot k uses bits 9k+8:9k.
REQ-014 o_dev_wdata  out  16  write data broadcast to all slots.
REQ-015 i_dev_dms  in  24  per-slot device code; 6 bits per slot.
REQ-016 i_dev_sc  in  64  per-slot read data; 16 bits per slot.
REQ-017 i_dev_zt  in  8  per-slot status; 2 bits per slot.
REQ-018 i_dev_zdqq  in  4  per-slot interrupt request.
REQ-019 i_inta  in  1  interrupt-acknowledge pulse.
REQ-020 o_int_req  out  1  interrupt request to the CPU.
REQ-021 o_int_dms  out  6  device code latched on INTA.

Function
REQ-022 FSM states: IDLE, DECODE, STROBE, CAPTURE, ACK.
REQ-023 IDLE: i_io_req high -> latch dms, kz and wdata, then go to DECODE; i_io_req is ignored in every other state.
REQ-024 DECODE, slot match: select the lowest-index slot whose DMS equals the latched dms, then go to STROBE.
REQ-025 DECODE, no match and dms != 6'o77: go to ACK with o_io_nodev=1, o_io_rdata=0, o_io_zt=0.
REQ-026 dms == 6'o77 (CPU code) is internal: KZS sets ION, KZC clears ION, DO loads mask <= wdata[3:0]; go to ACK with nodev=0 and rdata={12'b0,mask}.
REQ-027 STROBE: drive the latched kz on the selected slot only, for exactly STB_CYC cycles; all other slot fields stay 0.
REQ-028 CAPTURE: one cycle with kz deasserted; o_io_rdata <= selected SC; o_io_zt <= selected ZT (synchronised value).
REQ-029 ACK: o_io_ack=1 for exactly one cycle, then return to IDLE.
REQ-030 Ack latency for a matched slot: ack is high during the state after accept edge + STB_CYC + 2 edges.
REQ-031 o_io_rdata, o_io_zt and o_io_nodev hold their values until the next ACK.
REQ-032 o_dev_wdata = latched wdata at all times.
REQ-033 Mask bit k = 1 blocks slot k.
REQ-034 o_int_req = ION & |(zdqq_s & ~mask), registered.
REQ-035 i_inta: o_int_dms <= DMS of the lowest-index unmasked requesting slot, or 0 if none; ION <= 0.
REQ-036 i_inta and i_io_req in the same cycle are both served independently.
REQ-037 i_inta and a 077 KZS command on the same edge: i_inta wins, so ION=0.

Reset
REQ-038 i_rst_n low: state=IDLE, ION=0, mask=4'hF, and all outputs 0, including o_dev_kz, o_int_req and o_int_dms.
REQ-039 Reset asserted mid-operation aborts any strobe immediately (asynchronously).

Configuration
REQ-040 DJS130_IOC_SYNC_EN defined: i_dev_zt and i_dev_zdqq pass through two-flop synchronisers (zdqq_s latency 2).
REQ-041 DJS130_IOC_SYNC_EN undefined: a single register stage is used (latency 1); all other behaviour is unchanged.

Verification
REQ-042 Slot2 DMS=6'o10, SC=16'h0041, req dms=6'o10 kz=KZS, STB_CYC=2 -> o_dev_kz slot2 bit6 high for 2 cycles; ack with rdata=16'h0041, nodev=0.
REQ-043 req dms=6'o55, no slot matches -> ack 2 cycles after accept; nodev=1, rdata=0, all o_dev_kz stay 0.
REQ-044 Slots 1 and 3 both DMS=6'o10 -> only slot1 strobed.
REQ-045 077 DO wdata=4'b0101 then 077 KZS; slots 0 and 1 raise zdqq -> o_int_req=1; i_inta -> o_int_dms=slot1 DMS, ION=0, o_int_req=0.
REQ-046 Reset pulsed during STROBE -> o_dev_kz=0 at once; no ack; mask=4'hF.
REQ-047 With DJS130_IOC_SYNC_EN, zdqq rise -> o_int_req after 3 edges; without it, after 2 edges.

Source files
------------

// File: rtl/djs130_io_ctrl.sv
// DJS-130 I/O controller: decodes CPU I/O requests onto four device slots and merges interrupts.
// Optional macro DJS130_IOC_SYNC_EN selects two-flop synchronisers for device status/interrupts.
module djs130_io_ctrl #(
  parameter int unsigned STB_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_io_req,
  input  logic [5:0]  i_io_dms,
  input  logic [8:0]  i_io_kz,
  input  logic [15:0] i_io_wdata,
  output logic        o_io_ack,
  output logic [15:0] o_io_rdata,
  output logic [1:0]  o_io_zt,
  output logic        o_io_nodev,
  output logic [35:0] o_dev_kz,
  output logic [15:0] o_dev_wdata,
  input  logic [23:0] i_dev_dms,
  input  logic [63:0] i_dev_sc,
  input  logic [7:0]  i_dev_zt,
  input  logic [3:0]  i_dev_zdqq,
  input  logic        i_inta,
  output logic        o_int_req,
  output logic [5:0]  o_int_dms
);

  localparam logic [5:0] CpuDms = 6'o77;

  typedef enum logic [2:0] {StIdle, StDecode, StStrobe, StCapture, StAck} state_e;

  state_e      state_q, state_d;
  logic [5:0]  dms_q, dms_d;
  logic [8:0]  kz_q, kz_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ion_q, ion_d;
  logic [3:0]  mask_q, mask_d;
  logic        ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic [1:0]  zt_q, zt_d;
  logic        nodev_q, nodev_d;
  logic [35:0] dev_kz_q, dev_kz_d;
  logic        int_req_q, int_req_d;
  logic [5:0]  int_dms_q, int_dms_d;

  logic [7:0]  zt_s_q;
  logic [3:0]  zdqq_s_q;

`ifdef DJS130_IOC_SYNC_EN
  logic [7:0] zt_m_q;
  logic [3:0] zdqq_m_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zt_m_q   <= '0;
      zdqq_m_q <= '0;
      zt_s_q   <= '0;
      zdqq_s_q <= '0;
    end else begin
      zt_m_q   <= i_dev_zt;
      zdqq_m_q <= i_dev_zdqq;
      zt_s_q   <= zt_m_q;
      zdqq_s_q <= zdqq_m_q;
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zt_s_q   <= '0;
      zdqq_s_q <= '0;
    end else begin
      zt_s_q   <= i_dev_zt;
      zdqq_s_q <= i_dev_zdqq;
    end
  end
`endif

  // Descending scans so the lowest matching index is the one left standing.
  logic       hit;
  logic [1:0] hit_idx;
  logic [3:0] pend;
  logic [5:0] pick_dms;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = 2'd0;
    pend     = zdqq_s_q & ~mask_q;
    pick_dms = 6'd0;
    for (int k = 3; k >= 0; k--) begin
      if (i_dev_dms[6*k +: 6] == dms_q) begin
        hit     = 1'b1;
        hit_idx = 2'(k);
      end
      if (pend[k]) begin
        pick_dms = i_dev_dms[6*k +: 6];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dms_d     = dms_q;
    kz_d      = kz_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ion_d     = ion_q;
    mask_d    = mask_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    zt_d      = zt_q;
    nodev_d   = nodev_q;
    dev_kz_d  = dev_kz_q;
    int_dms_d = int_dms_q;
    int_req_d = ion_q & (|pend);

    unique case (state_q)
      StIdle: begin
        if (i_io_req) begin
          dms_d   = i_io_dms;
          kz_d    = i_io_kz;
          wdata_d = i_io_wdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dms_q == CpuDms) begin
          if (kz_q[7]) begin
            ion_d = 1'b0;
          end else if (kz_q[6]) begin
            ion_d = 1'b1;
          end
          if (kz_q[1]) begin
            mask_d = wdata_q[3:0];
          end
          rdata_d = {12'h000, mask_d};
          zt_d    = 2'b00;
          nodev_d = 1'b0;
          ack_d   = 1'b1;
          state_d = StAck;
        end else if (hit) begin
          sel_d                    = hit_idx;
          dev_kz_d                 = '0;
          dev_kz_d[9*hit_idx +: 9] = kz_q;
          cnt_d                    = 4'(STB_CYC - 1);
          state_d                  = StStrobe;
        end else begin
          rdata_d = 16'h0000;
          zt_d    = 2'b00;
          nodev_d = 1'b1;
          ack_d   = 1'b1;
          state_d = StAck;
        end
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          dev_kz_d = '0;
          state_d  = StCapture;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCapture: begin
        rdata_d = i_dev_sc[16*sel_q +: 16];
        zt_d    = zt_s_q[2*sel_q +: 2];
        nodev_d = 1'b0;
        ack_d   = 1'b1;
        state_d = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Interrupt acknowledge overrides any ION change made by a CPU command on the same edge.
    if (i_inta) begin
      ion_d     = 1'b0;
      int_dms_d = pick_dms;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      dms_q     <= '0;
      kz_q      <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      ion_q     <= 1'b0;
      mask_q    <= 4'hF;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      zt_q      <= '0;
      nodev_q   <= 1'b0;
      dev_kz_q  <= '0;
      int_req_q <= 1'b0;
      int_dms_q <= '0;
    end else begin
      state_q   <= state_d;
      dms_q     <= dms_d;
      kz_q      <= kz_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      ion_q     <= ion_d;
      mask_q    <= mask_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      zt_q      <= zt_d;
      nodev_q   <= nodev_d;
      dev_kz_q  <= dev_kz_d;
      int_req_q <= int_req_d;
      int_dms_q <= int_dms_d;
    end
  end

  assign o_io_ack    = ack_q;
  assign o_io_rdata  = rdata_q;
  assign o_io_zt     = zt_q;
  assign o_io_nodev  = nodev_q;
  assign o_dev_kz    = dev_kz_q;
  assign o_dev_wdata = wdata_q;
  assign o_int_req   = int_req_q;
  assign o_int_dms   = int_dms_q;

endmodule
